// File: rtl/puf_ro_compare_unit.sv
// RO-pair PUF: picks one ring oscillator per bank, counts synchronised edges, resolves one response bit.
// Window mode finishes 1+SETTLE_CYC+WINDOW cycles after start; race mode finishes the cycle after a threshold hit.
module puf_ro_compare_unit #(
    parameter int N_RO       = 16,
    parameter int SEL_W      = $clog2(N_RO),
    parameter int CNT_W      = 22,
    parameter int WINDOW     = 4096,
    parameter int SETTLE_CYC = 16
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic               mode,
    input  logic [2*SEL_W-1:0] challenge,
    input  logic [CNT_W-1:0]   threshold,
    input  logic [2*N_RO-1:0]  ro_in,
    output logic [2*N_RO-1:0]  ro_enable,
    output logic               busy,
    output logic               done,
    output logic               response,
    output logic               tie,
    output logic               timeout,
    output logic [CNT_W-1:0]   cnt_a,
    output logic [CNT_W-1:0]   cnt_b
);
    localparam int TMR_W = $clog2((WINDOW > SETTLE_CYC) ? WINDOW : SETTLE_CYC) + 1;

    typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_COUNT, S_DONE} state_t;

    state_t             state, state_nxt;
    logic [TMR_W-1:0]   tmr;
    logic               mode_q;
    logic [SEL_W-1:0]   sel_a, sel_b;
    logic [CNT_W-1:0]   thr_q;
    logic [1:0]         sync_a, sync_b;
    logic               prev_a, prev_b;
    logic [CNT_W-1:0]   ca, cb, ca_nxt, cb_nxt;
    logic [N_RO-1:0]    ro_a, ro_b, en_a, en_b;
    logic               edge_a, edge_b, inc_a, inc_b;
    logic               hit_a, hit_b, win_end, cnt_end;

    assign ro_a = ro_in[N_RO-1:0];
    assign ro_b = ro_in[2*N_RO-1:N_RO];

    assign edge_a = sync_a[1] & ~prev_a;
    assign edge_b = sync_b[1] & ~prev_b;
    assign inc_a  = (state == S_COUNT) && edge_a && (ca != '1);
    assign inc_b  = (state == S_COUNT) && edge_b && (cb != '1);
    assign ca_nxt = ca + CNT_W'(inc_a);
    assign cb_nxt = cb + CNT_W'(inc_b);

    // Race hits use the registered counts, so the exit lands one cycle after the threshold is reached.
    assign hit_a   = (ca >= thr_q);
    assign hit_b   = (cb >= thr_q);
    assign win_end = (tmr == TMR_W'(WINDOW - 1));
    assign cnt_end = (state == S_COUNT) && (state_nxt == S_DONE);

    assign busy = (state != S_IDLE);
    assign done = (state == S_DONE);

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (start) state_nxt = S_SETTLE;
            S_SETTLE: if (tmr == TMR_W'(SETTLE_CYC - 1)) state_nxt = S_COUNT;
            S_COUNT:  if (win_end || (!mode_q && (hit_a || hit_b))) state_nxt = S_DONE;
            S_DONE:   state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        en_a = '0;
        en_b = '0;
        if (state == S_SETTLE || state == S_COUNT) begin
            en_a[sel_a] = 1'b1;
            en_b[sel_b] = 1'b1;
        end
        ro_enable = {en_b, en_a};
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            tmr      <= '0;
            mode_q   <= 1'b0;
            sel_a    <= '0;
            sel_b    <= '0;
            thr_q    <= '0;
            sync_a   <= '0;
            sync_b   <= '0;
            prev_a   <= 1'b0;
            prev_b   <= 1'b0;
            ca       <= '0;
            cb       <= '0;
            response <= 1'b0;
            tie      <= 1'b0;
            timeout  <= 1'b0;
            cnt_a    <= '0;
            cnt_b    <= '0;
        end else begin
            state  <= state_nxt;
            sync_a <= {sync_a[0], ro_a[sel_a]};
            sync_b <= {sync_b[0], ro_b[sel_b]};
            prev_a <= sync_a[1];
            prev_b <= sync_b[1];

            if (state == S_IDLE || state_nxt != state) tmr <= '0;
            else                                      tmr <= tmr + TMR_W'(1);

            if (state == S_IDLE && start) begin
                mode_q  <= mode;
                sel_a   <= challenge[SEL_W-1:0];
                sel_b   <= challenge[2*SEL_W-1:SEL_W];
                thr_q   <= (threshold == '0) ? CNT_W'(1) : threshold;
                ca      <= '0;
                cb      <= '0;
                tie     <= 1'b0;
                timeout <= 1'b0;
            end else begin
                ca <= ca_nxt;
                cb <= cb_nxt;
            end

            // Final counts include any edge landing in the last COUNT cycle.
            if (cnt_end) begin
                cnt_a <= ca_nxt;
                cnt_b <= cb_nxt;
                if (mode_q) begin
                    response <= (ca_nxt > cb_nxt);
                    tie      <= (ca_nxt == cb_nxt);
                    timeout  <= 1'b0;
                end else if (hit_a && hit_b) begin
                    response <= 1'b0;
                    tie      <= 1'b1;
                    timeout  <= 1'b0;
                end else if (hit_a || hit_b) begin
                    response <= hit_a;
                    tie      <= 1'b0;
                    timeout  <= 1'b0;
                end else begin
                    response <= 1'b0;
                    tie      <= 1'b0;
                    timeout  <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_puf_ro_compare_unit.sv
// Directed bench for puf_ro_compare_unit (N_RO=4, CNT_W=8, WINDOW=64, SETTLE_CYC=4) plus a CNT_W=4 instance.
module tb_puf_ro_compare_unit;
    logic       clock = 1'b0;
    logic       reset;
    logic       start, mode;
    logic [3:0] challenge;
    logic [7:0] threshold;
    logic [7:0] ro_in, ro_enable;
    logic       busy, done, response, tie, timeout;
    logic [7:0] cnt_a, cnt_b;

    logic       start_s, mode_s;
    logic [3:0] challenge_s;
    logic [3:0] threshold_s;
    logic [7:0] ro_in_s, ro_enable_s;
    logic       busy_s, done_s, response_s, tie_s, timeout_s;
    logic [3:0] cnt_a_s, cnt_b_s;

    int checks = 0;
    int errors = 0;
    int ro_t   = 0;
    int per   [8];
    int per_s [8];
    int lat;

    always #5 clock = ~clock;

    puf_ro_compare_unit #(.N_RO(4), .CNT_W(8), .WINDOW(64), .SETTLE_CYC(4)) u_dut (
        .clock(clock), .reset(reset), .start(start), .mode(mode), .challenge(challenge),
        .threshold(threshold), .ro_in(ro_in), .ro_enable(ro_enable), .busy(busy), .done(done),
        .response(response), .tie(tie), .timeout(timeout), .cnt_a(cnt_a), .cnt_b(cnt_b)
    );

    puf_ro_compare_unit #(.N_RO(4), .CNT_W(4), .WINDOW(64), .SETTLE_CYC(4)) u_sat (
        .clock(clock), .reset(reset), .start(start_s), .mode(mode_s), .challenge(challenge_s),
        .threshold(threshold_s), .ro_in(ro_in_s), .ro_enable(ro_enable_s), .busy(busy_s),
        .done(done_s), .response(response_s), .tie(tie_s), .timeout(timeout_s),
        .cnt_a(cnt_a_s), .cnt_b(cnt_b_s)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // RO k is low for the first half of its period and high for the second; period 0 means stuck low.
    task automatic drive_ro();
        for (int i = 0; i < 8; i++) begin
            ro_in[i]   = (per[i] != 0) && ((ro_t % per[i]) >= per[i] / 2);
            ro_in_s[i] = (per_s[i] != 0) && ((ro_t % per_s[i]) >= per_s[i] / 2);
        end
    endtask

    task automatic tick();
        @(negedge clock);
        ro_t++;
        drive_ro();
    endtask

    task automatic set_per(input int p0, input int p1, input int p4, input int p6);
        for (int i = 0; i < 8; i++) per[i] = 0;
        per[0] = p0; per[1] = p1; per[4] = p4; per[6] = p6;
    endtask

    // Issues start at the current negedge and returns the cycle index at which done is seen.
    task automatic run(input logic m, input logic [3:0] ch, input logic [7:0] th,
                       input bit inject, output int l);
        logic [7:0] exp_en;
        exp_en = '0;
        exp_en[ch[1:0]] = 1'b1;
        exp_en[4 + ch[3:2]] = 1'b1;
        mode = m; challenge = ch; threshold = th; start = 1'b1;
        ro_t = 0;
        drive_ro();
        l = 0;
        while (l < 200) begin
            tick();
            l++;
            start = inject && (l == 2 || l == 20);
            if (start) begin
                mode = ~m; challenge = ~ch; threshold = 8'd1;
            end
            if (l == 1)  check("busy_c1", busy, 1);
            if (l == 2)  check("en_settle", ro_enable, exp_en);
            if (l == 10) check("en_count", ro_enable, exp_en);
            if (done) break;
        end
        start = 1'b0;
        check("done_busy", busy, 1);
        check("done_en", ro_enable, 0);
    endtask

    task automatic after_done(input logic exp_resp);
        tick();
        check("idle_done", done, 0);
        check("idle_busy", busy, 0);
        check("idle_resp", response, exp_resp);
    endtask

    initial begin
        int seen;
        reset = 1'b1; start = 1'b0; mode = 1'b0; challenge = '0; threshold = '0;
        start_s = 1'b0; mode_s = 1'b0; challenge_s = '0; threshold_s = '0;
        for (int i = 0; i < 8; i++) begin per[i] = 0; per_s[i] = 0; end
        drive_ro();
        repeat (3) tick();
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_en", ro_enable, 0);
        check("rst_flags", {response, tie, timeout}, 0);
        check("rst_cnt", {cnt_a, cnt_b}, 0);
        reset = 1'b0;
        tick();

        // Window: A1 period 8, B2 period 12, unselected neighbours toggling
        set_per(4, 8, 0, 12); per[5] = 4;
        run(1'b1, 4'b10_01, 8'd0, 1'b0, lat);
        check("w_lat", lat, 69);
        check("w_cnt_a", cnt_a, 8);
        check("w_cnt_b", cnt_b, 6);
        check("w_resp", response, 1);
        check("w_tie", tie, 0);
        after_done(1'b1);

        // Same run back-to-back with stray starts during SETTLE and COUNT
        run(1'b1, 4'b10_01, 8'd0, 1'b1, lat);
        check("ign_lat", lat, 69);
        check("ign_cnt", {cnt_a, cnt_b}, {8'd8, 8'd6});
        check("ign_resp", response, 1);
        after_done(1'b1);

        // Race: B (period 8) hits 5 before A (period 16)
        set_per(16, 0, 8, 0);
        run(1'b0, 4'b00_00, 8'd5, 1'b0, lat);
        check("r_lat", lat, 40);
        check("r_resp", response, 0);
        check("r_cnt_b", cnt_b, 5);
        check("r_cnt_a", cnt_a, 2);
        check("r_to", timeout, 0);
        check("r_tie", tie, 0);
        after_done(1'b0);

        // Race timeout: threshold unreachable
        set_per(16, 0, 16, 0);
        run(1'b0, 4'b00_00, 8'd200, 1'b0, lat);
        check("to_lat", lat, 69);
        check("to_flag", timeout, 1);
        check("to_resp", response, 0);
        check("to_cnt", {cnt_a, cnt_b}, {8'd4, 8'd4});
        after_done(1'b0);

        // Window tie, identical in-phase ROs
        set_per(8, 0, 8, 0);
        run(1'b1, 4'b00_00, 8'd0, 1'b0, lat);
        check("wt_tie", tie, 1);
        check("wt_resp", response, 0);
        check("wt_to", timeout, 0);
        check("wt_cnt", {cnt_a, cnt_b}, {8'd8, 8'd8});
        after_done(1'b0);

        // Race tie at threshold 3
        run(1'b0, 4'b00_00, 8'd3, 1'b0, lat);
        check("rt_lat", lat, 24);
        check("rt_tie", tie, 1);
        check("rt_resp", response, 0);
        check("rt_cnt", {cnt_a, cnt_b}, {8'd3, 8'd3});
        after_done(1'b0);

        // Threshold 0 behaves as 1
        set_per(8, 0, 0, 0);
        run(1'b0, 4'b00_00, 8'd0, 1'b0, lat);
        check("t0_lat", lat, 8);
        check("t0_resp", response, 1);
        check("t0_tie", tie, 0);
        check("t0_cnt_a", cnt_a, 1);
        after_done(1'b1);

        // Reset in the middle of COUNT
        set_per(4, 8, 0, 12);
        mode = 1'b1; challenge = 4'b10_01; threshold = '0; start = 1'b1;
        ro_t = 0;
        drive_ro();
        for (int k = 0; k < 30; k++) begin
            tick();
            start = 1'b0;
        end
        check("mid_busy_pre", busy, 1);
        reset = 1'b1;
        #1;
        check("mid_busy", busy, 0);
        check("mid_en", ro_enable, 0);
        check("mid_done", done, 0);
        check("mid_resp", response, 0);
        check("mid_cnt", {cnt_a, cnt_b}, 0);
        repeat (2) tick();
        reset = 1'b0;
        seen = 0;
        for (int k = 0; k < 80; k++) begin
            tick();
            if (done) seen++;
        end
        check("mid_no_done", seen, 0);
        run(1'b1, 4'b10_01, 8'd0, 1'b0, lat);
        check("post_lat", lat, 69);
        check("post_cnt", {cnt_a, cnt_b}, {8'd8, 8'd6});
        check("post_resp", response, 1);
        after_done(1'b1);

        // 4-bit counters: A period 4 would give 16 edges, must stop at 15
        for (int i = 0; i < 8; i++) per[i] = 0;
        per_s[0] = 4; per_s[4] = 32;
        mode_s = 1'b1; challenge_s = 4'b00_00; threshold_s = '0; start_s = 1'b1;
        ro_t = 0;
        drive_ro();
        lat = 0;
        while (lat < 200) begin
            tick();
            lat++;
            start_s = 1'b0;
            if (done_s) break;
        end
        check("sat_lat", lat, 69);
        check("sat_cnt_a", cnt_a_s, 15);
        check("sat_cnt_b", cnt_b_s, 2);
        check("sat_resp", response_s, 1);
        check("sat_tie", tie_s, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/puf_ro_compare_unit.md
Name: puf_ro_compare_unit

Overview:
- Parametrised successor of the 8-bit-challenge RO-race PUF subblock.
- Selects one ring oscillator from each of two banks from a challenge word and enables only that pair.
- Counts their edges synchronously in the system clock domain and produces one response bit.
- Two evaluation modes: race (first counter to reach a threshold wins) and window (compare counts after a fixed interval).
- Start/busy/done handshake plus tie/timeout flags; sits between the ring_osc arrays and the response-collection logic.

Parameters:
N_RO, 16, ring oscillators per bank (power of two, >=2)
SEL_W, $clog2(N_RO), derived; challenge bits per bank
CNT_W, 22, edge-counter width
WINDOW, 4096, COUNT-state length in clock cycles (window mode; race-mode timeout)
SETTLE_CYC, 16, cycles ROs run before counting starts

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high reset
start  in  1  single-cycle request; sampled only in IDLE
mode  in  1  0 = race, 1 = window; latched with start
challenge  in  2*SEL_W  [SEL_W-1:0] selects bank A RO, [2*SEL_W-1:SEL_W] selects bank B RO; latched with start
threshold  in  CNT_W  race target count; latched with start; 0 treated as 1
ro_in  in  2*N_RO  RO outputs; [N_RO-1:0] bank A, [2*N_RO-1:N_RO] bank B
ro_enable  out  2*N_RO  per-RO enable
busy  out  1  high from cycle after accepted start through DONE
done  out  1  one-cycle pulse, response valid
response  out  1  PUF bit, held until next accepted start
tie  out  1  equal result, held like response
timeout  out  1  race mode ended without reaching threshold, held
cnt_a, cnt_b  out  CNT_W each  final counts (debug), held

Behaviour:
- Reset (async): state IDLE; ro_enable=0, busy=0, done=0, response=0, tie=0, timeout=0, cnt_a=cnt_b=0, synchronizers cleared. Reset mid-evaluation aborts immediately; no done pulse.
- FSM: IDLE -> SETTLE -> COUNT -> DONE -> IDLE.
- IDLE: start=1 latches mode/challenge/threshold, clears counters -> SETTLE. start while not IDLE is ignored (no queuing).
- SETTLE: exactly SETTLE_CYC cycles; ro_enable has exactly two bits set: bit sel_a and bit N_RO+sel_b. Counters held at 0.
- COUNT: same ro_enable. Each selected ro_in passes a 2-flop synchronizer plus rising-edge detector; each detected edge increments its counter, saturating at 2^CNT_W-1. Inputs must toggle at <= clock/4; faster is unsupported.
- Window mode: COUNT lasts exactly WINDOW cycles, then DONE. response = (cnt_a > cnt_b); tie = (cnt_a == cnt_b), and response=0 when tied.
- Race mode: leave COUNT in the cycle after either counter reaches the threshold, or after WINDOW cycles.
  - A alone reached: response=1.
  - B alone reached: response=0.
  - Both reached in the same cycle: tie=1, response=0.
  - Neither reached by WINDOW: timeout=1, response=0.
- DONE: ro_enable=0; done=1 for one cycle; response/tie/timeout/cnt_a/cnt_b registered here and held until the next accepted start, which clears tie/timeout. busy=1 in DONE, 0 in the following IDLE cycle.
- Unselected ro_in bits are ignored.
- Latency: accepted start at cycle 0 -> busy=1 at cycle 1. Window mode: done at cycle 1+SETTLE_CYC+WINDOW. A ro_in rise is counted 3 cycles later.
- Back-to-back: start is accepted in the first IDLE cycle after DONE.

Test Plan:
(Configuration: N_RO=4, CNT_W=8, WINDOW=64, SETTLE_CYC=4; ro_in driven by bench with fixed periods.)
- Window, challenge=4'b10_01; RO A1 period 8 clk, RO B2 period 12 clk -> ro_enable=8'b0100_0010 during SETTLE/COUNT; done at cycle 69; cnt_a=8, cnt_b=5 (±1); response=1, tie=0.
- Race, threshold=5; A period 16, B period 8 -> B reaches 5 first; response=0, cnt_b=5, timeout=0; done well before WINDOW.
- Race, threshold=200; both periods 16 -> no counter reaches 200 in 64 cycles; timeout=1, response=0, done at cycle 69.
- Identical in-phase A/B: window mode -> tie=1, response=0. Race threshold=3 -> both reach 3 in the same cycle; tie=1, response=0.
- Start pulses during SETTLE and COUNT are ignored; outputs match a clean run. Reset asserted mid-COUNT -> all outputs 0 immediately, ro_enable=0, no done. A fresh start afterwards completes normally.
- CNT_W=4, window mode, A period 4 -> cnt_a saturates at 15, no wrap; response=1 against B period 32.
